// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s audio path: default sample width,
// burst counter width and the stream scheduler state encoding.
package i2s_pkg;

    localparam int DATA_W_DEF = 24;
    // Enough for BURST_LEN up to 16 (counter holds 0..BURST_LEN-1).
    localparam int BCNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after 'last',
// searching upward with wrap-around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] next,
    output logic         any
);

    always_comb begin
        int unsigned idx;
        next = last;
        any  = 1'b0;
        idx  = 0;
        // Offsets 1..N so the last winner is considered only after everyone else.
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(last) + i) % N;
            if (!any && req[W'(idx)]) begin
                any  = 1'b1;
                next = W'(idx);
            end
        end
    end

endmodule

// File: rtl/i2s_stream_scheduler.sv
// Round-robin scheduler sharing the i2s_master frame write port among
// NUM_SRC producers, with burst grants, enable mask and full back-pressure.
module i2s_stream_scheduler
    import i2s_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int BURST_LEN = 1,
    parameter  int CNT_W     = 32,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                      clk_soc,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_l,
    input  logic [NUM_SRC*DATA_W-1:0] src_r,
    input  logic [NUM_SRC-1:0]        enable_mask,
    input  logic                      full,
    output logic [DATA_W-1:0]         frame_in_l,
    output logic [DATA_W-1:0]         frame_in_r,
    output logic                      write_frame,
    output logic [SRC_W-1:0]          grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          frames_written
);

    state_e              state, state_n;
    logic [SRC_W-1:0]    grant_n;
    logic [BCNT_W-1:0]   burst_cnt, burst_cnt_n;

    logic [SRC_W-1:0]    pick_id;
    logic                pick_any;

    logic                cur_valid, cur_en, cur_rdy, accept;
    logic [DATA_W-1:0]   cur_l, cur_r;

    rr_pick #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_rr_pick (
        .req  (src_valid & enable_mask),
        .last (grant_id),
        .next (pick_id),
        .any  (pick_any)
    );

    // Select the granted source's request, enable and sample slices.
    always_comb begin
        cur_valid = 1'b0;
        cur_en    = 1'b0;
        cur_l     = '0;
        cur_r     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_id == SRC_W'(i)) begin
                cur_valid = src_valid[i];
                cur_en    = enable_mask[i];
                cur_l     = src_l[i*DATA_W +: DATA_W];
                cur_r     = src_r[i*DATA_W +: DATA_W];
            end
        end
    end

    // The !write_frame term absorbs the one-cycle lag of full after a write.
    assign cur_rdy = (state == BURST) && cur_en && !full && !write_frame;
    assign accept  = cur_rdy && cur_valid;
    assign busy    = (state == BURST);

    always_comb begin
        src_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_id == SRC_W'(i)) begin
                src_ready[i] = cur_rdy;
            end
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant_id;
        burst_cnt_n = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n     = BURST;
                    grant_n     = pick_id;
                    burst_cnt_n = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    if (burst_cnt == BCNT_W'(BURST_LEN - 1)) begin
                        state_n = IDLE;
                    end else begin
                        burst_cnt_n = burst_cnt + BCNT_W'(1);
                    end
                end else if (!cur_valid || !cur_en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_soc or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= SRC_W'(NUM_SRC - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            grant_id  <= grant_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    always_ff @(posedge clk_soc or posedge reset) begin
        if (reset) begin
            write_frame    <= 1'b0;
            frame_in_l     <= '0;
            frame_in_r     <= '0;
            frames_written <= '0;
        end else begin
            write_frame <= accept;
            if (accept) begin
                frame_in_l     <= cur_l;
                frame_in_r     <= cur_r;
                frames_written <= frames_written + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_stream_scheduler.sv
// Directed bench for i2s_stream_scheduler: one instance with BURST_LEN=1 and
// one with BURST_LEN=4, driven from shared inputs.
module tb_i2s_stream_scheduler;

    localparam int N  = 4;
    localparam int DW = 24;

    logic            clk_soc = 1'b0;
    logic            reset   = 1'b1;
    logic [N-1:0]    src_valid   = '0;
    logic [N-1:0]    enable_mask = '1;
    logic            full        = 1'b0;
    logic [N*DW-1:0] src_l = '0;
    logic [N*DW-1:0] src_r = '0;

    logic [N-1:0]  rdy1, rdy4;
    logic [DW-1:0] fl1, fr1, fl4, fr4;
    logic          wf1, wf4, busy1, busy4;
    logic [1:0]    gid1, gid4;
    logic [31:0]   fw1, fw4;

    logic          sel4 = 1'b0;
    logic          wf_s;
    logic [1:0]    gid_s;
    logic [DW-1:0] fl_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk_soc = ~clk_soc;

    assign wf_s  = sel4 ? wf4  : wf1;
    assign gid_s = sel4 ? gid4 : gid1;
    assign fl_s  = sel4 ? fl4  : fl1;

    i2s_stream_scheduler #(.NUM_SRC(N), .DATA_W(DW), .BURST_LEN(1), .CNT_W(32)) dut (
        .clk_soc(clk_soc), .reset(reset), .src_valid(src_valid), .src_ready(rdy1),
        .src_l(src_l), .src_r(src_r), .enable_mask(enable_mask), .full(full),
        .frame_in_l(fl1), .frame_in_r(fr1), .write_frame(wf1), .grant_id(gid1),
        .busy(busy1), .frames_written(fw1)
    );

    i2s_stream_scheduler #(.NUM_SRC(N), .DATA_W(DW), .BURST_LEN(4), .CNT_W(32)) dut4 (
        .clk_soc(clk_soc), .reset(reset), .src_valid(src_valid), .src_ready(rdy4),
        .src_l(src_l), .src_r(src_r), .enable_mask(enable_mask), .full(full),
        .frame_in_l(fl4), .frame_in_r(fr4), .write_frame(wf4), .grant_id(gid4),
        .busy(busy4), .frames_written(fw4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_soc);
        #1;
    endtask

    task automatic wait_wr(input string tag, input int maxc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (wf_s !== 1'b1 && n < maxc);
        chk(tag, 64'(wf_s), 64'd1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        src_valid   = '0;
        enable_mask = '1;
        full        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_slices();
        for (int i = 0; i < N; i++) begin
            src_l[i*DW +: DW] = 24'hA00000 | 24'(i);
            src_r[i*DW +: DW] = 24'hB00000 | 24'(i);
        end
    endtask

    initial begin
        // ---- reset values and single-frame latency ----
        tick();
        tick();
        chk("rst_wf",    64'(wf1),   64'd0);
        chk("rst_gid",   64'(gid1),  64'd3);
        chk("rst_fw",    64'(fw1),   64'd0);
        chk("rst_busy",  64'(busy1), 64'd0);
        chk("rst_rdy",   64'(rdy1),  64'd0);
        chk("rst_fl",    64'(fl1),   64'd0);
        reset = 1'b0;
        src_l[0 +: DW] = 24'h123456;
        src_r[0 +: DW] = 24'habcdef;
        src_valid = 4'b0001;
        tick();
        chk("t1_busy", 64'(busy1), 64'd1);
        chk("t1_gid",  64'(gid1),  64'd0);
        chk("t1_rdy",  64'(rdy1),  64'b0001);
        chk("t1_wf0",  64'(wf1),   64'd0);
        tick();
        chk("t1_wf",   64'(wf1), 64'd1);
        chk("t1_fl",   64'(fl1), 64'h123456);
        chk("t1_fr",   64'(fr1), 64'habcdef);
        chk("t1_fw",   64'(fw1), 64'd1);
        chk("t1_gid2", 64'(gid1), 64'd0);
        src_valid = '0;
        tick();
        chk("t1_wf_drop", 64'(wf1), 64'd0);
        chk("t1_hold",    64'(fl1), 64'h123456);

        // ---- all sources valid, BURST_LEN=1: 0,1,2,3,0,... ----
        do_reset();
        sel4 = 1'b0;
        load_slices();
        src_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_wr("t2_wr", 4);
            chk("t2_gid", 64'(gid1), 64'(k % 4));
            chk("t2_fl",  64'(fl1),  64'(24'hA00000 | 24'(k % 4)));
            chk("t2_fr",  64'(fr1),  64'(24'hB00000 | 24'(k % 4)));
            tick();
            chk("t2_gap", 64'(wf1), 64'd0);
        end
        chk("t2_fw", 64'(fw1), 64'd8);

        // ---- BURST_LEN=4, sources 1 and 2 ----
        do_reset();
        sel4 = 1'b1;
        src_valid = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            wait_wr("t3_wr", 4);
            chk("t3_gid", 64'(gid4), 64'((k < 4) ? 1 : 2));
            chk("t3_fl",  64'(fl4),  64'(24'hA00000 | 24'((k < 4) ? 1 : 2)));
            tick();
            chk("t3_gap", 64'(wf4), 64'd0);
        end
        chk("t3_fw", 64'(fw4), 64'd8);

        // ---- full back-pressure ----
        do_reset();
        sel4 = 1'b0;
        src_l[0 +: DW] = 24'h5A5A5A;
        src_valid = 4'b0001;
        full = 1'b1;
        tick();
        chk("t4_busy", 64'(busy1), 64'd1);
        chk("t4_rdy",  64'(rdy1),  64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_wf",   64'(wf1),   64'd0);
            chk("t4_hold_busy", 64'(busy1), 64'd1);
            chk("t4_hold_rdy",  64'(rdy1),  64'd0);
        end
        full = 1'b0;
        #1;
        chk("t4_rdy_rel", 64'(rdy1), 64'b0001);
        tick();
        chk("t4_wf", 64'(wf1), 64'd1);
        chk("t4_fl", 64'(fl1), 64'h5A5A5A);
        chk("t4_fw", 64'(fw1), 64'd1);
        src_valid = '0;
        tick();
        chk("t4_wf_once", 64'(wf1), 64'd0);
        chk("t4_fw_once", 64'(fw1), 64'd1);

        // ---- disable source 2 mid-burst ----
        do_reset();
        sel4 = 1'b1;
        load_slices();
        src_valid = 4'b1100;
        wait_wr("t5_wr2", 4);
        chk("t5_gid2", 64'(gid4), 64'd2);
        chk("t5_fl2",  64'(fl4),  64'h A00002);
        enable_mask = 4'b1011;
        #1;
        chk("t5_rdy_off", 64'(rdy4), 64'd0);
        tick();
        chk("t5_idle", 64'(busy4), 64'd0);
        chk("t5_wf0",  64'(wf4),   64'd0);
        tick();
        chk("t5_gid3", 64'(gid4), 64'd3);
        chk("t5_rdy3", 64'(rdy4), 64'b1000);
        wait_wr("t5_wr3", 4);
        chk("t5_fl3", 64'(fl4), 64'hA00003);
        chk("t5_fw",  64'(fw4), 64'd2);

        // ---- async reset during an in-flight write ----
        do_reset();
        sel4 = 1'b1;
        src_valid = 4'b0001;
        wait_wr("t6_wr", 4);
        chk("t6_busy_pre", 64'(busy4), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wf",   64'(wf4),   64'd0);
        chk("t6_busy", 64'(busy4), 64'd0);
        chk("t6_fw",   64'(fw4),   64'd0);
        chk("t6_gid",  64'(gid4),  64'd3);
        chk("t6_rdy",  64'(rdy4),  64'd0);
        #2;
        reset = 1'b0;
        src_valid = 4'b1111;
        tick();
        chk("t6_first", 64'(gid4),  64'd0);
        chk("t6_busy2", 64'(busy4), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
